// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman gain datapath (used by the gain ALU and the
// downstream update step).
//   DATA_W : width of covariance operands P and S
//   K_W    : width of the unsigned Q0.K_W gain
//   K_SAT  : saturated gain value (just below 1.0)
//   kalman_state_e : controller states of the gain divider
package kalman_pkg;

    localparam int DATA_W = 16;
    localparam int K_W = 13;
    localparam logic [12:0] K_SAT = 13'h1FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV0 = 2'd1,
        DIV1 = 2'd2,
        DONE = 2'd3
    } kalman_state_e;

endpackage

// File: rtl/kalman_frac_div_step.sv
// One combinational restoring-division iteration for a fractional quotient.
//   rem_in  : current partial remainder (DATA_W+1 bits)
//   s       : divisor
//   rem_out : remainder after doubling and conditional subtract
//   q_bit   : quotient bit produced by this iteration
module kalman_frac_div_step
    import kalman_pkg::*;
#(
    parameter int DATA_W = kalman_pkg::DATA_W
) (
    input  logic [DATA_W:0]   rem_in,
    input  logic [DATA_W-1:0] s,
    output logic [DATA_W:0]   rem_out,
    output logic              q_bit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W:0]   diff;

    always_comb begin
        shifted = {rem_in, 1'b0};
        q_bit   = (shifted >= {2'b00, s});
        // When the subtract happens the result is < 2*S, so it fits in
        // DATA_W+1 bits and modular subtraction is exact.
        diff    = shifted[DATA_W:0] - {1'b0, s};
        rem_out = q_bit ? diff : shifted[DATA_W:0];
    end

endmodule

// File: rtl/kalman_alu5.sv
// Kalman gain ALU: computes K0 = P00/S and K1 = P10/S as unsigned Q0.K_W
// gains using one shared bit-serial restoring divider (K_W cycles per gain).
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request, sampled only when not busy
//   P00_in, P10_in, S_in: covariance operands (latched at acceptance)
//   K0_out, K1_out      : gains, held until overwritten by the next request
//   busy                : division in progress
//   done                : one-cycle pulse when new gains are valid
//   div_zero            : last accepted request had S = 0
//
// state | meaning
// IDLE  | waiting for start
// DIV0  | K_W iterations of P00/S
// DIV1  | K_W iterations of P10/S
// DONE  | results valid, done pulse; start here is accepted
module kalman_alu5
    import kalman_pkg::*;
#(
    parameter int DATA_W = kalman_pkg::DATA_W,
    parameter int K_W    = kalman_pkg::K_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] P00_in,
    input  logic [DATA_W-1:0] P10_in,
    input  logic [DATA_W-1:0] S_in,
    output logic [K_W-1:0]    K0_out,
    output logic [K_W-1:0]    K1_out,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(K_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_W - 1);

    kalman_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   rem_q, rem_d;
    logic [K_W-1:0]    quo_q, quo_d;
    logic [DATA_W-1:0] p00_q, p00_d, p10_q, p10_d, s_q, s_d;
    logic [K_W-1:0]    k0_q, k0_d, k1_q, k1_d;
    logic              busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic [DATA_W:0]   step_rem;
    logic              step_bit;
    logic              accept, last_iter;

    kalman_frac_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_in  (rem_q),
        .s       (s_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    // Raw quotient is only meaningful when P < S; other cases are forced.
    function automatic logic [K_W-1:0] gain_sel(input logic [K_W-1:0] q,
                                                input logic [DATA_W-1:0] p,
                                                input logic [DATA_W-1:0] s);
        if (s == '0)
            return '0;
        else if (p >= s)
            return {K_W{1'b1}};
        else
            return q;
    endfunction

    assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign last_iter = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            p00_q   <= '0;
            p10_q   <= '0;
            s_q     <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            p00_q   <= p00_d;
            p10_q   <= p10_d;
            s_q     <= s_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DIV0;
            DIV0:    if (last_iter) state_d = DIV1;
            DIV1:    if (last_iter) state_d = DONE;
            DONE:    state_d = start ? DIV0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        p00_d = p00_q;
        p10_d = p10_q;
        s_d   = s_q;
        k0_d  = k0_q;
        k1_d  = k1_q;
        dz_d  = dz_q;
        if (accept) begin
            p00_d = P00_in;
            p10_d = P10_in;
            s_d   = S_in;
            rem_d = {1'b0, P00_in};
            cnt_d = '0;
            quo_d = '0;
            dz_d  = (S_in == '0);
        end else if ((state_q == DIV0) || (state_q == DIV1)) begin
            quo_d = {quo_q[K_W-2:0], step_bit};
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
                cnt_d = '0;
                if (state_q == DIV0) begin
                    k0_d  = gain_sel(quo_d, p00_q, s_q);
                    rem_d = {1'b0, p10_q};
                end else begin
                    k1_d  = gain_sel(quo_d, p10_q, s_q);
                end
            end
        end
        busy_d = (state_d == DIV0) || (state_d == DIV1);
        done_d = (state_d == DONE);
    end

    assign K0_out   = k0_q;
    assign K1_out   = k1_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_kalman_alu5.sv
module tb_kalman_alu5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] p00 = '0, p10 = '0, s_val = '0;
    logic [12:0] k0, k1;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [12:0] k0;
        logic [12:0] k1;
        logic        dz;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    kalman_alu5 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .P00_in   (p00),
        .P10_in   (p10),
        .S_in     (s_val),
        .K0_out   (k0),
        .K1_out   (k1),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [12:0] model_gain(input logic [15:0] p, input logic [15:0] s);
        logic [31:0] num;
        if (s == 0) return 13'd0;
        if (p >= s) return 13'h1FFF;
        num = {16'd0, p} << 13;
        return 13'(num / {16'd0, s});
    endfunction

    function automatic exp_t mk_exp(input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] s, input int c);
        exp_t e;
        e.k0 = model_gain(a, s);
        e.k1 = model_gain(b, s);
        e.dz = (s == 0);
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
                check_eq("k0", 32'(k0), 32'(e.k0));
                check_eq("k1", 32'(k1), 32'(e.k1));
                check_eq("div_zero", 32'(div_zero), 32'(e.dz));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            check_eq({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        step();
    endtask

    task automatic run_req(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] s);
        p00 = a; p10 = b; s_val = s;
        start = 1'b1;
        sb.push_back(mk_exp(a, b, s, cyc + 27));
        step();
        start = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        wait_drain(tag);
    endtask

    initial begin
        #1;
        check_eq("rst_k0", 32'(k0), 32'd0);
        check_eq("rst_k1", 32'(k1), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dz", 32'(div_zero), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        run_req("basic", 16'd100, 16'd50, 16'd200);
        run_req("third", 16'd1, 16'd2, 16'd3);
        run_req("sat", 16'd300, 16'd0, 16'd200);
        run_req("szero", 16'd500, 16'd500, 16'd0);
        run_req("clrdz", 16'd100, 16'd50, 16'd200);
        run_req("edge_eq", 16'hFFFF, 16'hFFFE, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] s, a, b;
            s = 16'($urandom_range(1, 65535));
            a = 16'($urandom_range(0, 65535)) % s;
            b = 16'($urandom_range(0, 65535));
            run_req("rand", a, b, s);
        end

        // Re-pulse while busy with new operands; originals must come out.
        p00 = 16'd100; p10 = 16'd50; s_val = 16'd200;
        start = 1'b1;
        sb.push_back(mk_exp(16'd100, 16'd50, 16'd200, cyc + 27));
        step();
        start = 1'b0;
        repeat (4) step();
        p00 = 16'd7; p10 = 16'd9; s_val = 16'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_drain("repulse");

        // Reset in the middle of a request.
        p00 = 16'd1; p10 = 16'd2; s_val = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        #1;
        check_eq("midrst_k0", 32'(k0), 32'd0);
        check_eq("midrst_k1", 32'(k1), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_dz", 32'(div_zero), 32'd0);
        step();
        rst = 1'b0;
        repeat (40) step();
        run_req("postrst", 16'd1, 16'd2, 16'd3);

        // Start held high: back-to-back results every 27 cycles.
        begin
            int c0;
            p00 = 16'd100; p10 = 16'd50; s_val = 16'd200;
            c0 = cyc;
            start = 1'b1;
            for (int k = 1; k <= 3; k++)
                sb.push_back(mk_exp(16'd100, 16'd50, 16'd200, c0 + 27 * k));
            for (int j = 1; j <= 81; j++) begin
                if (j == 81) start = 1'b0;
                step();
                check_eq("held_busy", 32'(busy), 32'((j % 27) != 0));
            end
            start = 1'b0;
            wait_drain("held");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
